// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU request port, debug/loader request port and the Memoria port.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_wr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_addr, mem_wr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_addr, mem_wr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single Memoria port between the CPU datapath and a debug/loader port.
// Debug port and its starvation counter exist only when MEM_ARB_DBG_EN is defined.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    // state | meaning
    // IDLE  | arbitrate the request inputs sampled at the next edge
    // ACC   | latched address/data on the memory port, write strobe for writes
    // RESP  | owner's ack; Memoria read data passed through and captured
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t            r_state;
    state_t            w_next;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;

    logic              w_dbg_win;
    logic              w_grant_cpu;
    logic              w_grant_dbg;
    logic              w_owner_dbg;
    logic              w_mem_wr;
    logic              w_resp;
    logic              w_cpu_ack;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_grant_cpu = (r_state == ST_IDLE) & bus.cpu_req & ~w_dbg_win;
    assign w_grant_dbg = (r_state == ST_IDLE) & w_dbg_win;

`ifdef MEM_ARB_DBG_EN
    logic [7:0]        r_starve;
    logic              r_owner_dbg;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              w_dbg_ack;

    // Debug wins only when alone or once the CPU has starved it LIMIT times in a row.
    assign w_dbg_win   = bus.dbg_req & (~bus.cpu_req | (r_starve == LIMIT));
    assign w_owner_dbg = r_owner_dbg;
    assign w_dbg_ack   = w_resp & r_owner_dbg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve <= 8'd0;
        end else if (!bus.dbg_req || w_grant_dbg) begin
            r_starve <= 8'd0;
        end else if (w_grant_cpu && (r_starve != LIMIT)) begin
            r_starve <= r_starve + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner_dbg <= 1'b0;
        end else if (w_grant_cpu || w_grant_dbg) begin
            r_owner_dbg <= w_grant_dbg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dbg_rdata <= '0;
        end else if (w_dbg_ack && !r_wr) begin
            r_dbg_rdata <= bus.mem_rdata;
        end
    end

    assign bus.dbg_ack   = w_dbg_ack;
    assign bus.dbg_rdata = (w_dbg_ack && !r_wr) ? bus.mem_rdata : r_dbg_rdata;
    assign w_sel_wr      = w_grant_dbg ? bus.dbg_wr    : bus.cpu_wr;
    assign w_sel_addr    = w_grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
    assign w_sel_wdata   = w_grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
`else
    logic w_unused;

    assign w_unused      = ^{bus.dbg_req, bus.dbg_wr, bus.dbg_addr, bus.dbg_wdata, w_grant_dbg, LIMIT};
    assign w_dbg_win     = 1'b0;
    assign w_owner_dbg   = 1'b0;
    assign bus.dbg_ack   = 1'b0;
    assign bus.dbg_rdata = '0;
    assign w_sel_wr      = bus.cpu_wr;
    assign w_sel_addr    = bus.cpu_addr;
    assign w_sel_wdata   = bus.cpu_wdata;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_mem_wr = 1'b0;
        w_resp   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_cpu || w_grant_dbg) begin
                    w_next = ST_ACC;
                end
            end
            ST_ACC: begin
                w_mem_wr = r_wr;
                w_next   = ST_RESP;
            end
            ST_RESP: begin
                w_resp = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // The memory port keeps the last granted access between transactions.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_cpu || w_grant_dbg) begin
            r_wr    <= w_sel_wr;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    assign w_cpu_ack = w_resp & ~w_owner_dbg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cpu_rdata <= '0;
        end else if (w_cpu_ack && !r_wr) begin
            r_cpu_rdata <= bus.mem_rdata;
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.cpu_ack   = w_cpu_ack;
    assign bus.cpu_rdata = (w_cpu_ack && !r_wr) ? bus.mem_rdata : r_cpu_rdata;
    assign bus.cpu_stall = bus.cpu_req & ~w_cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random CPU/debug traffic, checked every cycle
// against a transaction-level model of grants, memory contents and read-data registers.
module tb_mem_arbiter;

    localparam int STARVE = 8;
`ifdef MEM_ARB_DBG_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Memoria stand-in: synchronous read, word-indexed by the low address bits
    logic [31:0] mem_store [int];
    int          mem_k;
    always @(posedge clock) begin
        mem_k = int'(bus.mem_addr[5:0]);
        bus.mem_rdata <= mem_store.exists(mem_k) ? mem_store[mem_k] : 32'h1000_0000 + mem_k;
        if (bus.mem_wr) mem_store[mem_k] = bus.mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one transaction at a time ----------------
    logic [31:0] ref_wr [int];
    int          cyc = 0, t_n = 0, free_at = 0, m_starve = 0;
    bit          has_t = 0, t_dbg = 0, t_wr = 0, cw, dw;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [31:0] m_addr = '0, m_wdata = '0, m_cpu_rd = '0, m_dbg_rd = '0;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int k;
        k = int'(a[5:0]);
        return ref_wr.exists(k) ? ref_wr[k] : 32'h1000_0000 + k;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc = 0; has_t = 0; free_at = 0; m_starve = 0;
            m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_dbg_rd = '0;
        end else begin
            if (has_t && cyc == t_n + 1 && !t_wr) begin
                if (t_dbg) m_dbg_rd = t_rdata;
                else       m_cpu_rd = t_rdata;
            end
            cyc++;
            cw = 0; dw = 0;
            if (cyc >= free_at) begin
                dw = DBG_EN && bus.dbg_req && (!bus.cpu_req || m_starve == STARVE);
                cw = bus.cpu_req && !dw;
            end
            if (cw || dw) begin
                has_t   = 1; t_n = cyc; free_at = cyc + 3; t_dbg = dw;
                t_wr    = dw ? bus.dbg_wr    : bus.cpu_wr;
                t_addr  = dw ? bus.dbg_addr  : bus.cpu_addr;
                t_wdata = dw ? bus.dbg_wdata : bus.cpu_wdata;
                t_rdata = ref_read(t_addr);
                if (t_wr) ref_wr[int'(t_addr[5:0])] = t_wdata;
                m_addr  = t_addr; m_wdata = t_wdata;
            end
            if (!bus.dbg_req || dw) m_starve = 0;
            else if (cw && m_starve < STARVE) m_starve++;
        end
    end

    bit          c_acc, c_resp, c_cack, c_dack;
    logic [31:0] c_crd, c_drd;
    always begin
        @(posedge clock);
        #1;
        if (reset) begin
            c_acc  = has_t && cyc == t_n;
            c_resp = has_t && cyc == t_n + 1;
            c_cack = c_resp && !t_dbg;
            c_dack = c_resp && t_dbg;
            c_crd  = (c_cack && !t_wr) ? t_rdata : m_cpu_rd;
            c_drd  = (c_dack && !t_wr) ? t_rdata : m_dbg_rd;
            chk("mem_wr",    bus.mem_wr,    c_acc && t_wr);
            chk("mem_addr",  bus.mem_addr,  m_addr);
            chk("mem_wdata", bus.mem_wdata, m_wdata);
            chk("cpu_ack",   bus.cpu_ack,   c_cack);
            chk("cpu_rdata", bus.cpu_rdata, c_crd);
            chk("cpu_stall", bus.cpu_stall, bus.cpu_req && !c_cack);
            chk("dbg_ack",   bus.dbg_ack,   c_dack);
            chk("dbg_rdata", bus.dbg_rdata, c_drd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit d, input logic req, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (d) begin
            bus.dbg_req = req; bus.dbg_wr = wr; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
        end else begin
            bus.cpu_req = req; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
    endtask

    task automatic txn(input bit d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output int wr_cyc, output int stall_cnt, output logic [31:0] rdata);
        logic ack;
        lat = 0; wr_cyc = 0; stall_cnt = 0;
        @(negedge clock);
        drive(d, 1'b1, wr, addr, wdata);
        do begin
            @(negedge clock);
            lat++;
            if (bus.mem_wr) wr_cyc++;
            if (bus.cpu_stall) stall_cnt++;
            ack = d ? bus.dbg_ack : bus.cpu_ack;
        end while (!ack && lat < 40);
        rdata = d ? bus.dbg_rdata : bus.cpu_rdata;
        if (!ack) begin
            checks++; errors++;
            $display("FAIL txn_timeout port=%0d no ack after %0d cycles", d, lat);
        end
        drive(d, 1'b0, wr, addr, wdata);
    endtask

    task automatic new_req(input bit d);
        drive(d, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom);
    endtask

    task automatic agent(input bit d);
        logic req, ack;
        req = d ? bus.dbg_req : bus.cpu_req;
        ack = d ? bus.dbg_ack : bus.cpu_ack;
        if (req) begin
            if (ack) begin
                if ($urandom_range(0, 1) == 1) new_req(d);
                else drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end else if ($urandom_range(0, 2) == 0) begin
            new_req(d);
        end
    endtask

    // ---------------- main sequence ----------------
    int          lat, wc, sc, got, guard, dack_cnt;
    logic [31:0] rd;
    int          seq [32];

    initial begin
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clock);
        chk("rst_mem_wr",    bus.mem_wr,    32'h0);
        chk("rst_mem_addr",  bus.mem_addr,  32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_cpu_ack",   bus.cpu_ack,   32'h0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rst_dbg_ack",   bus.dbg_ack,   32'h0);
        chk("rst_dbg_rdata", bus.dbg_rdata, 32'h0);

        reset = 1'b1;
        @(negedge clock);
        chk("first_acc_addr", bus.mem_addr, 32'h10);
        chk("first_acc_ack",  bus.cpu_ack,  32'h0);
        @(negedge clock);
        chk("first_ack",   bus.cpu_ack,   32'h1);
        chk("first_rdata", bus.cpu_rdata, 32'h1000_0010);
        bus.cpu_req = 1'b0;

        txn(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, lat, wc, sc, rd);
        chk("wr_latency",   lat, 32'd2);
        chk("wr_strobe_cy", wc,  32'd1);
        txn(1'b0, 1'b0, 32'h20, 32'h0, lat, wc, sc, rd);
        chk("rd_latency",   lat, 32'd2);
        chk("rd_data",      rd,  32'hDEAD_BEEF);
        chk("rd_stall_cy",  sc,  32'd1);

`ifdef MEM_ARB_DBG_EN
        txn(1'b1, 1'b0, 32'h20, 32'h0, lat, wc, sc, rd);
        chk("dbg_lone_latency", lat, 32'd2);
        chk("dbg_lone_rdata",   rd,  32'hDEAD_BEEF);
        chk("dbg_keeps_cpu_rd", bus.cpu_rdata, 32'hDEAD_BEEF);

        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        got = 0; guard = 0;
        while (got < 18 && guard < 200) begin
            @(negedge clock);
            guard++;
            if (bus.cpu_ack) begin seq[got] = 0; got++; end
            if (bus.dbg_ack) begin
                seq[got] = 1; got++;
                chk("both_dbg_rdata", bus.dbg_rdata, 32'hDEAD_BEEF);
                chk("both_cpu_rdata", bus.cpu_rdata, 32'h1000_0010);
            end
        end
        bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
        chk("both_grant_count", got, 32'd18);
        for (int i = 0; i < got; i++) chk("grant_order", seq[i], (i % 9 == 8) ? 32'd1 : 32'd0);
`else
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h5555_AAAA);
        dack_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bus.dbg_ack) dack_cnt++;
        end
        chk("dbg_lone_never_ack", dack_cnt, 32'd0);

        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        got = 0; guard = 0;
        while (got < 9 && guard < 100) begin
            @(negedge clock);
            guard++;
            if (bus.dbg_ack) dack_cnt++;
            if (bus.cpu_ack) begin
                got++;
                chk("nodbg_dbg_rdata", bus.dbg_rdata, 32'h0);
            end
        end
        bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
        chk("nodbg_cpu_grants", got, 32'd9);
        chk("nodbg_dbg_acks",   dack_cnt, 32'd0);
`endif

        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1, 32'h3F, 32'h1234_5678);
        @(negedge clock);
        chk("mid_acc_wr",   bus.mem_wr,   32'h1);
        chk("mid_acc_addr", bus.mem_addr, 32'h3F);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_mem_wr",    bus.mem_wr,    32'h0);
        chk("mid_rst_cpu_ack",   bus.cpu_ack,   32'h0);
        chk("mid_rst_mem_addr",  bus.mem_addr,  32'h0);
        chk("mid_rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("mid_rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        bus.cpu_req = 1'b0;
        @(negedge clock);
        chk("mid_rst_no_ack", bus.cpu_ack, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("post_rst_no_ack", bus.cpu_ack, 32'h0);
        end
        txn(1'b0, 1'b0, 32'h20, 32'h0, lat, wc, sc, rd);
        chk("post_rst_latency", lat, 32'd2);
        chk("post_rst_rdata",   rd,  32'hDEAD_BEEF);

        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            agent(1'b0);
            agent(1'b1);
        end
        guard = 0;
        while ((bus.cpu_req || bus.dbg_req) && guard < 60) begin
            @(negedge clock);
            guard++;
            if (bus.cpu_req && bus.cpu_ack) bus.cpu_req = 1'b0;
            if (bus.dbg_req && (bus.dbg_ack || !DBG_EN)) bus.dbg_req = 1'b0;
        end
        chk("drain_done", {31'd0, bus.cpu_req | bus.dbg_req}, 32'h0);
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and access sequencer for the single-port `Memoria` in the multicycle MIPS core. It shares the port between the CPU datapath (fetch and load/store via the control unit) and a debug/loader port. The CPU gets fixed priority with a starvation bound for debug. `cpu_stall` tells the control unit to hold its current state while an access is pending.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 8, consecutive lost arbitrations after which debug wins; legal range 1..255

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`
- `cpu_wr`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  registered read data
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`
- `dbg_req`, `dbg_wr`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_ack`: same as the `cpu_*` ports, for the debug port
- `mem_addr`  out  ADDR_W  to `Memoria` address
- `mem_wr`  out  1  to `Memoria` write enable
- `mem_wdata`  out  DATA_W  to `Memoria` write data
- `mem_rdata`  in  DATA_W  from `Memoria`; valid one cycle after the address is applied

## Operation
- State machine: IDLE, ACC, RESP.
- **IDLE**
  - Arbitrate on registered request inputs.
  - On a grant, latch the winner's addr/wdata/wr and a grant-owner bit, then go to ACC.
  - With no request, stay in IDLE.
- **ACC**
  - `mem_addr`/`mem_wdata` come from the latched registers.
  - `mem_wr` = latched wr, high for exactly this one cycle.
  - Always go to RESP.
- **RESP**
  - Pulse the owner's ack.
  - On a read, capture `mem_rdata` into the owner's rdata register during this cycle. It is visible combinationally with ack and holds until that owner's next read completes.
  - On a write, the rdata register is unchanged.
  - Always go to IDLE.
- **Priority**
  - The CPU wins when both requests are present, unless the starvation counter equals `STARVE_LIMIT`; then debug wins.
  - A lone requester always wins.
- **Starvation counter**
  - 8 bits.
  - Increments on each IDLE grant to the CPU while `dbg_req` is high.
  - Clears on a debug grant or whenever `dbg_req` is low.
  - Saturates at `STARVE_LIMIT`.
- **Outside ACC**
  - `mem_wr` = 0.
  - `mem_addr`/`mem_wdata` hold the last latched values.
- **Request drop**: a requester dropping req after grant is a protocol violation. The access still completes and ack still pulses.
- **Debug reads**: `cpu_rdata` is never altered by a debug access.

## Timing
- Request first seen high in IDLE at edge N:
  - ACC in cycle N+1, with `mem_wr` high during N+1 for writes.
  - RESP and ack in cycle N+2.
  - Back in IDLE at N+3.
- Latency: 2 cycles from grant to ack. Throughput: one access per 3 cycles.
- A requester may present its next request in the cycle after ack. That request is arbitrated in IDLE.
- Both requesters may be granted on alternate transactions; there is no back-to-back to the same port without an IDLE cycle.
- **Reset (async assert)**, immediately, including mid-ACC:
  - state = IDLE
  - `mem_wr` = 0
  - both acks = 0
  - `cpu_rdata` = `dbg_rdata` = 0
  - `mem_addr` = `mem_wdata` = 0
  - starvation counter = 0
  - An interrupted write is undefined in memory. No ack is ever issued for an interrupted access.
- **Reset release**: synchronous to `clock`. The first grant is possible at the first edge after deassertion.

## Configuration
- `MEM_ARB_DBG_EN` defined:
  - Debug port and starvation counter are fully functional as above.
- `MEM_ARB_DBG_EN` undefined:
  - Debug logic is not synthesised.
  - `dbg_req`, `dbg_wr`, `dbg_addr`, `dbg_wdata` are ignored.
  - `dbg_ack` = 0 and `dbg_rdata` = 0 constantly.
  - Only the CPU is granted; CPU timing is identical.

## Test plan
- **Reset values**: hold `reset` = 0 with `cpu_req` = 1 → all outputs 0 and no ack. Release, then `cpu_req` read of addr 0x10 → `mem_addr` = 0x10 in cycle N+1, `cpu_ack` + `cpu_rdata` = memory word in N+2.
- **CPU write then read**: CPU write 0xDEADBEEF to 0x20 → `mem_wr` high exactly one cycle. Following read of 0x20 → `cpu_rdata` = 0xDEADBEEF, `cpu_stall` high until ack.
- **Simultaneous requests**: both requesters continuously, `STARVE_LIMIT` = 8 → grants are 8 CPU then 1 debug, repeating. Debug read of 0x20 returns 0xDEADBEEF; `cpu_rdata` is unchanged by it.
- **Lone debug request**: debug request with `cpu_req` = 0 → granted at the next IDLE edge; counter stays 0.
- **Reset mid-access**: assert `reset` during ACC of a CPU write → `mem_wr` drops asynchronously, no `cpu_ack`. After release, state is IDLE.
- **Macro undefined**: with `MEM_ARB_DBG_EN` undefined and `dbg_req` = 1 forever → `dbg_ack` never asserts and the CPU gets every grant.
